// File: rtl/cheshire_eoc_monitor.sv
// cheshire_eoc_monitor: watches per-channel scratch-register writes for
// end-of-computation (EOC) markers. A write whose bit0 is set marks the
// channel done; bits [DataWidth-1:1] are kept as that channel's exit code.
// A run starts with an arm_i pulse and ends in DONE (all channels reported)
// or TIMEOUT (cycle budget exhausted while channels are still pending).
// Optional feature macro: CHESHIRE_EOC_TIMEOUT_EN builds the cycle counter
// and the TIMEOUT exit; without it, RUN can only end in DONE.
//
// Write strobes: wr_valid_i[c] is a one-cycle qualifier with no ready/back-
// pressure; the monitor always accepts a write in the cycle it is presented,
// and it only acts on it in RUN for a channel that has not yet reported.
module cheshire_eoc_monitor #(
  parameter int unsigned NumChannels  = 2,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned TimeoutWidth = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   arm_i,
  input  logic [NumChannels-1:0]                 wr_valid_i,
  input  logic [NumChannels*DataWidth-1:0]       wr_data_i,
  input  logic [TimeoutWidth-1:0]                timeout_cycles_i,
  output logic [NumChannels-1:0]                 done_o,
  output logic [NumChannels*(DataWidth-1)-1:0]   exit_code_o,
  output logic                                   busy_o,
  output logic                                   all_done_o,
  output logic                                   fail_o,
  output logic                                   timeout_o,
  output logic                                   irq_o
);

  localparam int unsigned CodeWidth = DataWidth - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  state_e                            state_q, state_d;
  logic                              start;
  logic                              expire;
  logic [NumChannels-1:0]            eoc;
  logic [NumChannels-1:0]            done_q, done_d;
  logic [NumChannels*CodeWidth-1:0]  code_q, code_d;
  logic                              irq_q, irq_d;

  // arm_i only starts a run outside RUN; it is ignored while a run is active
  assign start = arm_i && (state_q != RUN);

  // Capture the first EOC per channel; a new run wipes previous results
  always_comb begin
    eoc    = '0;
    done_d = done_q;
    code_d = code_q;
    for (int c = 0; c < NumChannels; c++) begin
      eoc[c] = (state_q == RUN) && wr_valid_i[c] && wr_data_i[c*DataWidth] && !done_q[c];
      if (eoc[c]) begin
        done_d[c]                    = 1'b1;
        code_d[c*CodeWidth +: CodeWidth] = wr_data_i[c*DataWidth+1 +: CodeWidth];
      end
    end
    if (start) begin
      done_d = '0;
      code_d = '0;
    end
  end

`ifdef CHESHIRE_EOC_TIMEOUT_EN
  logic [TimeoutWidth-1:0] cnt_q;

  // Run-length counter: cleared on arm, counts RUN cycles, sticks at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if ((state_q == RUN) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + TimeoutWidth'(1);
    end
  end

  assign expire = (state_q == RUN) && (timeout_cycles_i != '0) &&
                  (cnt_q == timeout_cycles_i - TimeoutWidth'(1));
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles_i;
  assign expire         = 1'b0;
`endif

  // State, result and interrupt registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      done_q  <= '0;
      code_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      code_q  <= code_d;
      irq_q   <= irq_d;
    end
  end

  // Next state: completion of every channel beats a simultaneous timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (arm_i) state_d = RUN;
      RUN: begin
        if (&done_d)     state_d = DONE;
        else if (expire) state_d = TIMEOUT;
      end
      DONE, TIMEOUT: if (arm_i) state_d = RUN;
      default:       state_d = IDLE;
    endcase
  end

  // Interrupt fires on the edge that enters a terminal state
  always_comb begin
    irq_d = (state_d != state_q) && ((state_d == DONE) || (state_d == TIMEOUT));
  end

  // Status outputs decoded from registered state and results
  always_comb begin
    busy_o      = (state_q == RUN);
    all_done_o  = (state_q == DONE);
`ifdef CHESHIRE_EOC_TIMEOUT_EN
    timeout_o   = (state_q == TIMEOUT);
`else
    timeout_o   = 1'b0;
`endif
    irq_o       = irq_q;
    done_o      = done_q;
    exit_code_o = code_q;
    fail_o      = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      if (done_q[c] && (code_q[c*CodeWidth +: CodeWidth] != '0)) fail_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_cheshire_eoc_monitor.sv
// tb_cheshire_eoc_monitor: directed scenarios plus randomized runs checked
// against a run-level behavioural model of the EOC monitor.
module tb_cheshire_eoc_monitor;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int CW = DW - 1;
`ifdef CHESHIRE_EOC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              arm;
  logic [N-1:0]      wr_valid;
  logic [N*DW-1:0]   wr_data;
  logic [TW-1:0]     tmo;
  logic [N-1:0]      done;
  logic [N*CW-1:0]   exit_code;
  logic              busy, all_done, fail, timeout, irq;

  int checks = 0;
  int errors = 0;

  cheshire_eoc_monitor #(
    .NumChannels (N),
    .DataWidth   (DW),
    .TimeoutWidth(TW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .arm_i           (arm),
    .wr_valid_i      (wr_valid),
    .wr_data_i       (wr_data),
    .timeout_cycles_i(tmo),
    .done_o          (done),
    .exit_code_o     (exit_code),
    .busy_o          (busy),
    .all_done_o      (all_done),
    .fail_o          (fail),
    .timeout_o       (timeout),
    .irq_o           (irq)
  );

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 running, 2 finished ok, 3 timed out
  int           m_phase = 0;
  logic [N-1:0] m_done  = '0;
  logic [CW-1:0] m_code [N];
  int           m_cnt   = 0;
  logic         m_irq   = 1'b0;

  task automatic model_update();
    m_irq = 1'b0;
    if (rst) begin
      m_phase = 0; m_done = '0; m_cnt = 0;
      for (int c = 0; c < N; c++) m_code[c] = '0;
    end else if (m_phase != 1) begin
      if (arm) begin
        m_phase = 1; m_done = '0; m_cnt = 0;
        for (int c = 0; c < N; c++) m_code[c] = '0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        if (wr_valid[c] && wr_data[c*DW] && !m_done[c]) begin
          m_done[c] = 1'b1;
          m_code[c] = wr_data[c*DW+1 +: CW];
        end
      end
      if (m_done == {N{1'b1}}) begin
        m_phase = 2; m_irq = 1'b1;
      end else if (TO_EN && tmo != 0 && m_cnt == int'(tmo) - 1) begin
        m_phase = 3; m_irq = 1'b1;
      end
      if (m_cnt < (1 << TW) - 1) m_cnt++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model sees the same inputs as the DUT, then strobes drop.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    arm      = 1'b0;
    wr_valid = '0;
  endtask

  task automatic wr(input int c, input logic [DW-1:0] d);
    wr_valid[c]        = 1'b1;
    wr_data[c*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; wr_valid = '0; wr_data = '0; tmo = '0;
    for (int c = 0; c < N; c++) m_code[c] = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({done, exit_code, busy, all_done, fail, timeout, irq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b busy=%b all_done=%b fail=%b timeout=%b irq=%b, want all 0",
               done, busy, all_done, fail, timeout, irq);
    end
  endtask

  task automatic test_basic();
    tmo = '0;
    arm = 1'b1; tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    wr(0, 32'h1); tick();
    checks++;
    if (done !== 2'b01 || all_done !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL basic_first: got done=%b all_done=%b irq=%b want 01/0/0", done, all_done, irq);
    end
    tick(); tick();
    wr(1, 32'h1); tick();
    checks++;
    if (done !== 2'b11 || all_done !== 1'b1 || fail !== 1'b0 || irq !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_final: got done=%b all_done=%b fail=%b irq=%b busy=%b want 11/1/0/1/0",
                         done, all_done, fail, irq, busy);
    end
    tick();
    checks++;
    if (irq !== 1'b0 || all_done !== 1'b1 || done !== 2'b11) begin
      errors++; $display("FAIL basic_hold: got irq=%b all_done=%b done=%b want 0/1/11", irq, all_done, done);
    end
  endtask

  task automatic test_simultaneous();
    arm = 1'b1; tick();
    wr(0, 32'h7); wr(1, 32'h1); tick();
    checks++;
    if (exit_code[0 +: CW] !== 31'd3 || all_done !== 1'b1 || fail !== 1'b1 || done !== 2'b11 || irq !== 1'b1) begin
      errors++; $display("FAIL simul: got code0=%0d all_done=%b fail=%b done=%b irq=%b want 3/1/1/11/1",
                         exit_code[0 +: CW], all_done, fail, done, irq);
    end
  endtask

  task automatic test_rearm();
    arm = 1'b1; tick();
    checks++;
    if (busy !== 1'b1 || done !== '0 || exit_code !== '0 || fail !== 1'b0 || all_done !== 1'b0) begin
      errors++; $display("FAIL rearm: got busy=%b done=%b fail=%b all_done=%b want 1/00/0/0", busy, done, fail, all_done);
    end
  endtask

  task automatic test_ignore();
    do_reset();
    tmo = '0;
    arm = 1'b1; tick();
    wr(0, 32'h4); tick();
    checks++;
    if (done !== 2'b00) begin errors++; $display("FAIL ignore_bit0: got done=%b want 00", done); end
    wr(0, 32'h1); tick();
    wr(0, 32'h5); arm = 1'b1; tick();
    checks++;
    if (done !== 2'b01 || exit_code[0 +: CW] !== '0 || busy !== 1'b1 || fail !== 1'b0) begin
      errors++; $display("FAIL ignore_first_wins: got done=%b code0=%0d busy=%b fail=%b want 01/0/1/0",
                         done, exit_code[0 +: CW], busy, fail);
    end
    wr(1, 32'h3); tick();
    checks++;
    if (fail !== 1'b1 || exit_code[CW +: CW] !== 31'd1 || all_done !== 1'b1) begin
      errors++; $display("FAIL ignore_finish: got fail=%b code1=%0d all_done=%b want 1/1/1",
                         fail, exit_code[CW +: CW], all_done);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tmo = 4'd10;
    arm = 1'b1; tick();
    wr(0, 32'h1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 9) begin
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL timeout_early: got timeout=%b busy=%b want 0/1", timeout, busy);
        end
      end
    end
    checks++;
    if (timeout !== TO_EN || irq !== TO_EN || busy !== !TO_EN || done !== 2'b01) begin
      errors++; $display("FAIL timeout_expire: got timeout=%b irq=%b busy=%b done=%b want %b/%b/%b/01",
                         timeout, irq, busy, done, TO_EN, TO_EN, !TO_EN);
    end
    tick();
    checks++;
    if (irq !== 1'b0 || timeout !== TO_EN) begin
      errors++; $display("FAIL timeout_hold: got irq=%b timeout=%b want 0/%b", irq, timeout, TO_EN);
    end
    tmo = '0;
    wr(1, 32'h1); tick();
  endtask

  task automatic test_priority();
    do_reset();
    tmo = 4'd3;
    arm = 1'b1; tick();
    wr(0, 32'h1); tick();
    tick();
    wr(1, 32'h1); tick();
    checks++;
    if (all_done !== 1'b1 || timeout !== 1'b0 || irq !== 1'b1) begin
      errors++; $display("FAIL priority: got all_done=%b timeout=%b irq=%b want 1/0/1", all_done, timeout, irq);
    end
    tmo = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    tmo = '0;
    arm = 1'b1; tick();
    repeat (20) tick();
    tmo = 4'd4;
    repeat (20) tick();
    checks++;
    if (busy !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL saturation: got busy=%b timeout=%b want 1/0", busy, timeout);
    end
    tmo = '0;
    wr(0, 32'h1); wr(1, 32'h1); tick();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    tmo = '0;
    arm = 1'b1; tick();
    wr(0, 32'h5); tick();
    checks++;
    if (done !== 2'b01 || exit_code[0 +: CW] !== 31'd2 || fail !== 1'b1) begin
      errors++; $display("FAIL midrun_partial: got done=%b code0=%0d fail=%b want 01/2/1", done, exit_code[0 +: CW], fail);
    end
    rst = 1'b1; arm = 1'b1; wr(1, 32'h1); tick();
    rst = 1'b0;
    checks++;
    if ({done, exit_code, busy, all_done, fail, timeout, irq} !== '0) begin
      errors++; $display("FAIL midrun_reset: got done=%b busy=%b all_done=%b fail=%b irq=%b want all 0",
                         done, busy, all_done, fail, irq);
    end
    arm = 1'b1; tick();
    wr(0, 32'h1); wr(1, 32'h1); tick();
    checks++;
    if (all_done !== 1'b1 || fail !== 1'b0 || done !== 2'b11 || exit_code !== '0) begin
      errors++; $display("FAIL midrun_clean: got all_done=%b fail=%b done=%b want 1/0/11", all_done, fail, done);
    end
  endtask

  task automatic test_random();
    logic [N*CW-1:0] exp_code;
    logic            exp_fail;
    logic [DW-1:0]   d;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 11) == 0) begin
        arm = 1'b1;
        tmo = TW'($urandom_range(0, 12));
      end
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          d = $urandom;
          if ($urandom_range(0, 1) == 1) d[DW-1:1] = '0;
          wr(c, d);
        end
      end
      tick();
      rst = 1'b0;
      exp_fail = 1'b0;
      for (int c = 0; c < N; c++) begin
        exp_code[c*CW +: CW] = m_code[c];
        if (m_done[c] && m_code[c] != '0) exp_fail = 1'b1;
      end
      checks++;
      if (done !== m_done || exit_code !== exp_code || fail !== exp_fail ||
          busy !== (m_phase == 1) || all_done !== (m_phase == 2) ||
          timeout !== (m_phase == 3) || irq !== m_irq) begin
        errors++;
        $display("FAIL random[%0d]: got done=%b fail=%b busy=%b all_done=%b timeout=%b irq=%b code=%h want done=%b fail=%b phase=%0d irq=%b code=%h",
                 i, done, fail, busy, all_done, timeout, irq, exit_code, m_done, exp_fail, m_phase, m_irq, exp_code);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_rearm();
    test_ignore();
    test_timeout();
`ifdef CHESHIRE_EOC_TIMEOUT_EN
    test_priority();
    test_saturation();
`endif
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cheshire_eoc_monitor.md
CHESHIRE_EOC_MONITOR -- requirements
Module: cheshire_eoc_monitor

Interface
REQ-001 SHALL have parameter NumChannels, default 2, meaning number of monitored end-of-computation (EOC) channels (1..16).
REQ-002 SHALL have parameter DataWidth, default 32, meaning width of each channel's scratch-register write data (>= 2).
REQ-003 SHALL have parameter TimeoutWidth, default 32, meaning width of the timeout cycle counter.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-007 SHALL have port arm_i  input  1  single-cycle pulse; starts a monitoring run.
REQ-008 SHALL have port wr_valid_i  input  NumChannels  per-channel scratch-register write strobe.
REQ-009 SHALL have port wr_data_i  input  NumChannels*DataWidth  per-channel write data; channel c occupies bits [c*DataWidth +: DataWidth].
REQ-010 SHALL have port timeout_cycles_i  input  TimeoutWidth  run timeout in cycles; 0 disables the timeout.
REQ-011 SHALL have port done_o  output  NumChannels  per-channel sticky EOC flag.
REQ-012 SHALL have port exit_code_o  output  NumChannels*(DataWidth-1)  per-channel captured exit code.
REQ-013 SHALL have port busy_o, all_done_o, fail_o, timeout_o  output  1 each  run status: running, all channels done, any channel nonzero exit code, timeout expired.
REQ-014 SHALL have port irq_o  output  1  single-cycle pulse on entry to DONE or TIMEOUT.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE, TIMEOUT.
REQ-016 IDLE: arm_i=1 -> RUN next cycle; clear done_o, exit_code_o, fail_o, timeout_o, and the cycle counter to 0.
REQ-017 RUN: a channel write counts as EOC only when wr_valid_i[c]=1 and wr_data_i[c] bit0=1.
REQ-018 RUN, on a channel's first EOC: done_o[c] SHALL set one cycle after the write; exit_code_o[c] SHALL capture data bits [DataWidth-1:1].
REQ-019 Writes with bit0=0, and writes to a channel whose done_o[c]=1, SHALL be ignored (first EOC wins).
REQ-020 Simultaneous EOC writes on several channels in the same cycle SHALL all be captured in that cycle.
REQ-021 RUN: the cycle counter increments by 1 per cycle and saturates at all-ones (no wrap-around).
REQ-022 RUN -> DONE when all done_o bits are 1, including the cycle in which the final write(s) are captured; all_done_o=1 in DONE.
REQ-023 RUN -> TIMEOUT when timeout_cycles_i != 0 and counter == timeout_cycles_i-1 while channels are still pending; timeout_o=1.
REQ-024 If the final EOC and timeout expiry occur in the same cycle, DONE SHALL take priority.
REQ-025 fail_o SHALL equal the OR over channels of (done_o[c] and exit_code_o[c] != 0); it updates in the same cycle as done_o.
REQ-026 busy_o SHALL be 1 only in RUN.
REQ-027 DONE/TIMEOUT: results hold; arm_i=1 -> clear results and return to RUN (re-arm); arm_i in RUN SHALL be ignored.
REQ-028 irq_o SHALL be high for exactly one cycle, the first cycle in DONE or TIMEOUT.

Reset
REQ-029 rst_i=1 -> state IDLE, counter 0, all outputs 0, on the next rising edge; a reset asserted mid-RUN SHALL discard partial results.
REQ-030 Reset SHALL take priority over arm_i and all writes in the same cycle.

Configuration
REQ-031 Macro CHESHIRE_EOC_TIMEOUT_EN defined -> the counter and TIMEOUT state are built as specified.
REQ-032 Macro CHESHIRE_EOC_TIMEOUT_EN undefined -> no counter is built; timeout_cycles_i is ignored; timeout_o is tied 0; RUN exits only to DONE.

Verification
REQ-033 NumChannels=2, arm, ch0 writes 0x1, 3 cycles later ch1 writes 0x1 -> done_o 01 then 11, all_done_o=1, fail_o=0, irq_o one pulse.
REQ-034 arm, ch0 writes 0x7 and ch1 writes 0x1 in the same cycle -> exit_code_o[0]=3, DONE next cycle, fail_o=1.
REQ-035 arm, ch0 writes 0x4 (bit0=0), then 0x1, then 0x5 -> exit_code_o[0]=0; the first and third writes are ignored.
REQ-036 timeout_cycles_i=10, only ch0 completes -> timeout_o=1 on the 10th cycle after entering RUN, irq_o pulses (with the macro defined); without the macro, the bench stays in RUN.
REQ-037 rst_i mid-RUN after ch0 done -> all outputs 0, IDLE; re-arm yields a clean run.
REQ-038 In DONE, pulse arm_i -> results cleared, busy_o=1 next cycle.
